dna_ascii_feeder: RTL and testbench

Upstream stage of the spaced-pattern DNA detector. Accepts a byte stream of ASCII nucleotide characters over a valid/ready handshake and converts each one to the detector's 2-bit code (A=00, T=01, C=10, G=11). It buffers the codes in a small FIFO and presents them one per cycle on a valid/ready output. Invalid characters are consumed, dropped and counted.

---
 rtl/dna_ascii_feeder_if.sv | 23 ++
 rtl/dna_ascii_feeder.sv | 143 ++++++++++++++
 tb/tb_dna_ascii_feeder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dna_ascii_feeder_if.sv
// Handshake bundle between the ASCII byte source, the nucleotide feeder and
// the downstream pattern detector.
//   ch_in / ch_valid / ch_ready : ASCII character stream into the feeder
//   x_out / x_valid / x_ready   : 2-bit nucleotide code stream out of the feeder
// master = the environment (byte source plus code sink); slave = the feeder.
interface dna_ascii_feeder_if;
    logic [7:0] ch_in;
    logic       ch_valid;
    logic       ch_ready;
    logic [1:0] x_out;
    logic       x_valid;
    logic       x_ready;

    modport master (
        output ch_in, ch_valid, x_ready,
        input  ch_ready, x_out, x_valid
    );

    modport slave (
        input  ch_in, ch_valid, x_ready,
        output ch_ready, x_out, x_valid
    );
endinterface

// File: rtl/dna_ascii_feeder.sv
// dna_ascii_feeder: converts ASCII nucleotide characters (A/T/C/G, either case)
// into 2-bit codes (A=00, T=01, C=10, G=11) and buffers them in a small FIFO.
// Bytes that are not nucleotides are consumed, dropped and counted.
// Ports:
//   clk1      : clock, rising edge
//   rst1_n    : asynchronous active-low reset
//   flush     : synchronous clear of the FIFO contents (wins over push/pop)
//   bus       : character input and code output handshakes (slave side)
//   err       : one-cycle pulse after an invalid byte was consumed
//   fill      : FIFO occupancy, 0..DEPTH
//   bad_count : saturating count of dropped bytes
module dna_ascii_feeder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                clk1,
    input  logic                rst1_n,
    input  logic                flush,
    dna_ascii_feeder_if.slave   bus,
    output logic                err,
    output logic [ADDR_W:0]     fill,
    output logic [7:0]          bad_count
);

    localparam logic [ADDR_W:0]   FILL_FULL_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE_C  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   FILL_ZERO_C = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE_C   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO_C  = ADDR_W'(0);

    // Returns {valid, code}; valid=0 for any byte that is not a nucleotide.
    function automatic logic [2:0] encode_char(input logic [7:0] c);
        logic [2:0] r;
        case (c)
            8'h41, 8'h61: r = 3'b100;
            8'h54, 8'h74: r = 3'b101;
            8'h43, 8'h63: r = 3'b110;
            8'h47, 8'h67: r = 3'b111;
            default:      r = 3'b000;
        endcase
        return r;
    endfunction

    logic [1:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   fill_r;
    logic              x_valid_r;
    logic              ch_ready_r;
    logic              err_r;
    logic [7:0]        bad_count_r;

    logic [2:0]        enc_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              bad_s;
    logic [ADDR_W:0]   fill_next_s;
    logic [1:0]        x_out_s;

    // Handshake decode and next occupancy; flush discards the pending push/pop
    // but the byte offered this cycle is still handshaken and classified.
    always_comb begin
        enc_s       = encode_char(bus.ch_in);
        accept_s    = bus.ch_valid & ch_ready_r;
        bad_s       = accept_s & ~enc_s[2];
        push_s      = 1'b0;
        pop_s       = 1'b0;
        fill_next_s = fill_r;
        if (flush) begin
            push_s      = 1'b0;
            pop_s       = 1'b0;
            fill_next_s = FILL_ZERO_C;
        end else begin
            push_s = accept_s & enc_s[2];
            pop_s  = x_valid_r & bus.x_ready;
            if (push_s && !pop_s) begin
                fill_next_s = fill_r + FILL_ONE_C;
            end else if (!push_s && pop_s) begin
                fill_next_s = fill_r - FILL_ONE_C;
            end else begin
                fill_next_s = fill_r;
            end
        end
    end

    // FIFO storage, pointers, status flags and the invalid-byte counter.
    // ch_ready/x_valid are registered from the next occupancy so they track fill exactly.
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
            wr_ptr_r    <= PTR_ZERO_C;
            rd_ptr_r    <= PTR_ZERO_C;
            fill_r      <= FILL_ZERO_C;
            x_valid_r   <= 1'b0;
            ch_ready_r  <= 1'b1;
            err_r       <= 1'b0;
            bad_count_r <= 8'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= enc_s[1:0];
            end
            if (flush) begin
                wr_ptr_r <= PTR_ZERO_C;
                rd_ptr_r <= PTR_ZERO_C;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end
            end
            fill_r     <= fill_next_s;
            x_valid_r  <= (fill_next_s != FILL_ZERO_C);
            ch_ready_r <= (fill_next_s != FILL_FULL_C);
            err_r      <= bad_s;
            if (bad_s && (bad_count_r != 8'hFF)) begin
                bad_count_r <= bad_count_r + 8'h01;
            end
        end
    end

    // Head of the FIFO, forced to 00 while empty so stale storage never shows.
    always_comb begin
        x_out_s = 2'b00;
        if (x_valid_r) begin
            x_out_s = mem_r[rd_ptr_r];
        end else begin
            x_out_s = 2'b00;
        end
    end

    assign bus.x_out    = x_out_s;
    assign bus.x_valid  = x_valid_r;
    assign bus.ch_ready = ch_ready_r;
    assign err          = err_r;
    assign fill         = fill_r;
    assign bad_count    = bad_count_r;

endmodule

// File: tb/tb_dna_ascii_feeder.sv
module tb_dna_ascii_feeder;

    logic       clk1;
    logic       rst1_n;
    logic       flush;
    logic       err;
    logic [2:0] fill;
    logic [7:0] bad_count;

    dna_ascii_feeder_if bus_if ();

    dna_ascii_feeder #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk1      (clk1),
        .rst1_n    (rst1_n),
        .flush     (flush),
        .bus       (bus_if),
        .err       (err),
        .fill      (fill),
        .bad_count (bad_count)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard of codes expected at the output, plus err/bad_count model.
    logic [1:0] sb_q [$];
    logic       m_err = 1'b0;
    int         m_bad = 0;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    function automatic int model_code(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u == "A") return 0;
        if (u == "T") return 1;
        if (u == "C") return 2;
        if (u == "G") return 3;
        return -1;
    endfunction

    // Reference model, evaluated mid-cycle: check current outputs, then
    // predict the effect of the coming rising edge.
    always @(negedge clk1) begin
        int  sz;
        int  code;
        logic acc;
        if (!rst1_n) begin
            sb_q.delete();
            m_err = 1'b0;
            m_bad = 0;
        end else begin
            sz = sb_q.size();
            checks++;
            if (fill !== 3'(sz)) begin
                errors++; $display("FAIL mon_fill got %0d want %0d", fill, sz);
            end
            checks++;
            if (bus_if.x_valid !== (sz != 0)) begin
                errors++; $display("FAIL mon_x_valid got %0b want %0b", bus_if.x_valid, sz != 0);
            end
            checks++;
            if (bus_if.ch_ready !== (sz != 4)) begin
                errors++; $display("FAIL mon_ch_ready got %0b want %0b", bus_if.ch_ready, sz != 4);
            end
            checks++;
            if (err !== m_err) begin
                errors++; $display("FAIL mon_err got %0b want %0b", err, m_err);
            end
            checks++;
            if (bad_count !== 8'(m_bad)) begin
                errors++; $display("FAIL mon_bad_count got %0d want %0d", bad_count, m_bad);
            end
            checks++;
            if (sz == 0) begin
                if (bus_if.x_out !== 2'b00) begin
                    errors++; $display("FAIL mon_x_out_empty got %0b want 00", bus_if.x_out);
                end
            end else if (bus_if.x_out !== sb_q[0]) begin
                errors++; $display("FAIL mon_x_out got %0b want %0b", bus_if.x_out, sb_q[0]);
            end
            acc  = bus_if.ch_valid && (sz != 4);
            code = model_code(bus_if.ch_in);
            m_err = acc && (code < 0);
            if (m_err && m_bad < 255) m_bad++;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (bus_if.x_ready && sz != 0) void'(sb_q.pop_front());
                if (acc && code >= 0) sb_q.push_back(2'(code));
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        flush = 1'b0;
        bus_if.ch_in = 8'h00;
        bus_if.ch_valid = 1'b0;
        bus_if.x_ready = 1'b0;
        repeat (3) tick();
        rst1_n = 1'b1;
        tick();
        checks++;
        if (fill !== 3'd0 || bus_if.x_valid !== 1'b0 || bus_if.x_out !== 2'b00 ||
            bus_if.ch_ready !== 1'b1 || err !== 1'b0 || bad_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got fill=%0d xv=%0b xo=%0b rdy=%0b err=%0b bad=%0d want 0 0 00 1 0 0",
                     fill, bus_if.x_valid, bus_if.x_out, bus_if.ch_ready, err, bad_count);
        end
    endtask

    task automatic test_stream();
        logic [7:0] s [9];
        logic [1:0] c [9];
        s = '{"C","G","A","T","T","C","G","C","C"};
        c = '{2'b10,2'b11,2'b00,2'b01,2'b01,2'b10,2'b11,2'b10,2'b10};
        bus_if.x_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_if.ch_in = s[i];
            bus_if.ch_valid = 1'b1;
            tick();
            checks++;
            if (fill !== 3'd1 || bus_if.x_out !== c[i] || bus_if.x_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got fill=%0d x_out=%0b want fill=1 x_out=%0b",
                         i, fill, bus_if.x_out, c[i]);
            end
        end
        bus_if.ch_valid = 1'b0;
        tick();
        checks++;
        if (fill !== 3'd0) begin
            errors++; $display("FAIL stream_drain got %0d want 0", fill);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s [4];
        s = '{"a","c","g","t"};
        bus_if.x_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.ch_in = s[i];
            bus_if.ch_valid = 1'b1;
            tick();
        end
        bus_if.ch_in = "A";
        repeat (2) tick();
        checks++;
        if (fill !== 3'd4 || bus_if.ch_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got fill=%0d rdy=%0b want 4 0", fill, bus_if.ch_ready);
        end
        bus_if.x_ready = 1'b1;
        tick();
        checks++;
        if (fill !== 3'd3 || bus_if.ch_ready !== 1'b1 || bus_if.x_out !== 2'b10) begin
            errors++;
            $display("FAIL bp_pop_only got fill=%0d rdy=%0b x_out=%0b want 3 1 10",
                     fill, bus_if.ch_ready, bus_if.x_out);
        end
        tick();
        checks++;
        if (fill !== 3'd3 || bus_if.x_out !== 2'b11) begin
            errors++; $display("FAIL bp_push_pop got fill=%0d x_out=%0b want 3 11", fill, bus_if.x_out);
        end
        bus_if.ch_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (fill !== 3'd0) begin
            errors++; $display("FAIL bp_drain got %0d want 0", fill);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [5];
        s = '{"G","t","C","a","T"};
        bus_if.x_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.ch_in = s[i];
            bus_if.ch_valid = 1'b1;
            if (i == 2) bus_if.x_ready = 1'b1;
            tick();
            if (i >= 2) begin
                checks++;
                if (fill !== 3'd2) begin
                    errors++; $display("FAIL b2b_fill_%0d got %0d want 2", i, fill);
                end
            end
        end
        bus_if.ch_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_invalid();
        bus_if.x_ready = 1'b0;
        bus_if.ch_valid = 1'b1;
        bus_if.ch_in = "C";
        tick();
        bus_if.ch_in = "X";
        tick();
        bus_if.ch_in = "G";
        checks++;
        if (err !== 1'b1 || bad_count !== 8'd1) begin
            errors++; $display("FAIL inv_err_pulse got err=%0b bad=%0d want 1 1", err, bad_count);
        end
        tick();
        bus_if.ch_valid = 1'b0;
        checks++;
        if (err !== 1'b0 || fill !== 3'd2 || bus_if.x_out !== 2'b10) begin
            errors++;
            $display("FAIL inv_after got err=%0b fill=%0d x_out=%0b want 0 2 10", err, fill, bus_if.x_out);
        end
        bus_if.x_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        bus_if.x_ready = 1'b1;
        bus_if.ch_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus_if.ch_in = 8'h30 + 8'(i % 10);
            tick();
        end
        bus_if.ch_valid = 1'b0;
        tick();
        checks++;
        if (bad_count !== 8'd255) begin
            errors++; $display("FAIL sat_bad_count got %0d want 255", bad_count);
        end
    endtask

    task automatic test_flush_reset();
        logic [7:0] s [3];
        s = '{"T","T","G"};
        bus_if.x_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.ch_in = s[i];
            bus_if.ch_valid = 1'b1;
            tick();
        end
        bus_if.ch_in = "C";
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus_if.ch_valid = 1'b0;
        checks++;
        if (fill !== 3'd0 || bus_if.x_valid !== 1'b0) begin
            errors++; $display("FAIL flush got fill=%0d xv=%0b want 0 0", fill, bus_if.x_valid);
        end
        bus_if.ch_valid = 1'b1;
        bus_if.ch_in = "A";
        tick();
        bus_if.ch_in = "c";
        tick();
        #2 rst1_n = 1'b0;
        #1;
        checks++;
        if (fill !== 3'd0 || bus_if.x_valid !== 1'b0 || bus_if.x_out !== 2'b00 ||
            bus_if.ch_ready !== 1'b1 || err !== 1'b0 || bad_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got fill=%0d xv=%0b xo=%0b rdy=%0b err=%0b bad=%0d want 0 0 00 1 0 0",
                     fill, bus_if.x_valid, bus_if.x_out, bus_if.ch_ready, err, bad_count);
        end
        bus_if.ch_valid = 1'b0;
        tick();
        rst1_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_invalid();
        test_saturation();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
